// File: rtl/weight_bank_writer_if.sv
// Stream-in / BRAM-out bundle for the weight bank writer.
// The slave side is the writer; the master side is the DMA and the BRAM array.
interface weight_bank_writer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tlast;
    logic [NUM_BANKS-1:0]  bank_en;
    logic [ADDR_WIDTH-1:0] bank_addr;
    logic [DATA_WIDTH-1:0] bank_dout;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_axis_tready, bank_en, bank_addr, bank_dout
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_axis_tready, bank_en, bank_addr, bank_dout
    );
endinterface

// File: rtl/weight_bank_writer.sv
// Distributes a weight stream round-robin over NUM_BANKS BRAMs, in runs of
// (words_m1+1) words per bank, alternating ping/pong address halves per transfer.
module weight_bank_writer #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_BANKS   = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int CNT_WIDTH   = 11,
    parameter int TRANS_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   cfg_words_m1_i,
    input  logic [TRANS_WIDTH-1:0] cfg_trans_m1_i,
    input  logic [ADDR_WIDTH-1:0]  cfg_pong_base_i,
    input  logic                   cfg_pp_en_i,
    weight_bank_writer_if.slave    wb,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_len_o
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WORK = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]             state_q,     state_d;
    logic [CNT_WIDTH-1:0]   words_m1_q,  words_m1_d;
    logic [TRANS_WIDTH-1:0] trans_m1_q,  trans_m1_d;
    logic [ADDR_WIDTH-1:0]  pong_base_q, pong_base_d;
    logic                   pp_en_q,     pp_en_d;
    logic [CNT_WIDTH-1:0]   word_cnt_q,  word_cnt_d;
    logic [BW-1:0]          bank_idx_q,  bank_idx_d;
    logic [TRANS_WIDTH-1:0] trans_cnt_q, trans_cnt_d;
    logic                   pingpong_q,  pingpong_d;
    logic                   past_end_q,  past_end_d;
    logic                   err_q,       err_d;
    logic [NUM_BANKS-1:0]   bank_en_q,   bank_en_d;
    logic [ADDR_WIDTH-1:0]  bank_addr_q, bank_addr_d;
    logic [DATA_WIDTH-1:0]  bank_dout_q, bank_dout_d;

    logic                   tready_s;
    logic                   accept_s;
    logic                   last_word_s;
    logic                   last_bank_s;
    logic                   is_last_s;
    logic [ADDR_WIDTH-1:0]  base_s;

    function automatic logic [NUM_BANKS-1:0] onehot(input logic [BW-1:0] idx);
        logic [NUM_BANKS-1:0] v;
        v      = {NUM_BANKS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    assign tready_s    = (state_q == ST_WORK);
    assign accept_s    = wb.s_axis_tvalid & tready_s;
    assign last_word_s = (word_cnt_q == words_m1_q);
    assign last_bank_s = (bank_idx_q == BW'(NUM_BANKS - 1));
    assign is_last_s   = last_word_s & last_bank_s;
    assign base_s      = (pp_en_q & pingpong_q) ? pong_base_q : {ADDR_WIDTH{1'b0}};

    // Next-state: FSM, shadow config, bank/word/transfer counters and write port.
    always_comb begin
        state_d     = state_q;
        words_m1_d  = words_m1_q;
        trans_m1_d  = trans_m1_q;
        pong_base_d = pong_base_q;
        pp_en_d     = pp_en_q;
        word_cnt_d  = word_cnt_q;
        bank_idx_d  = bank_idx_q;
        trans_cnt_d = trans_cnt_q;
        pingpong_d  = pingpong_q;
        past_end_d  = past_end_q;
        err_d       = err_q;
        bank_en_d   = {NUM_BANKS{1'b0}};
        bank_addr_d = bank_addr_q;
        bank_dout_d = bank_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    words_m1_d  = cfg_words_m1_i;
                    trans_m1_d  = cfg_trans_m1_i;
                    pong_base_d = cfg_pong_base_i;
                    pp_en_d     = cfg_pp_en_i;
                    err_d       = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                word_cnt_d  = {CNT_WIDTH{1'b0}};
                bank_idx_d  = {BW{1'b0}};
                trans_cnt_d = {TRANS_WIDTH{1'b0}};
                pingpong_d  = 1'b0;
                past_end_d  = 1'b0;
                state_d     = ST_WORK;
            end
            ST_WORK: begin
                if (accept_s) begin
                    bank_en_d   = onehot(bank_idx_q);
                    bank_addr_d = base_s + ADDR_WIDTH'(word_cnt_q);
                    bank_dout_d = wb.s_axis_tdata;
                    // Any beat after the expected final one, or an early TLAST, is a framing error.
                    if ((wb.s_axis_tlast & ~is_last_s) | past_end_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (wb.s_axis_tlast) begin
                        word_cnt_d = {CNT_WIDTH{1'b0}};
                        bank_idx_d = {BW{1'b0}};
                        past_end_d = 1'b0;
                        pingpong_d = ~pingpong_q;
                        if (trans_cnt_q == trans_m1_q) begin
                            state_d = ST_DONE;
                        end else begin
                            trans_cnt_d = trans_cnt_q + TRANS_WIDTH'(1);
                        end
                    end else if (last_word_s) begin
                        word_cnt_d = {CNT_WIDTH{1'b0}};
                        if (last_bank_s) begin
                            bank_idx_d = {BW{1'b0}};
                            past_end_d = 1'b1;
                        end else begin
                            bank_idx_d = bank_idx_q + BW'(1);
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    bank_en_d = {NUM_BANKS{1'b0}};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset also drops any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            words_m1_q  <= {CNT_WIDTH{1'b0}};
            trans_m1_q  <= {TRANS_WIDTH{1'b0}};
            pong_base_q <= {ADDR_WIDTH{1'b0}};
            pp_en_q     <= 1'b0;
            word_cnt_q  <= {CNT_WIDTH{1'b0}};
            bank_idx_q  <= {BW{1'b0}};
            trans_cnt_q <= {TRANS_WIDTH{1'b0}};
            pingpong_q  <= 1'b0;
            past_end_q  <= 1'b0;
            err_q       <= 1'b0;
            bank_en_q   <= {NUM_BANKS{1'b0}};
            bank_addr_q <= {ADDR_WIDTH{1'b0}};
            bank_dout_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            words_m1_q  <= words_m1_d;
            trans_m1_q  <= trans_m1_d;
            pong_base_q <= pong_base_d;
            pp_en_q     <= pp_en_d;
            word_cnt_q  <= word_cnt_d;
            bank_idx_q  <= bank_idx_d;
            trans_cnt_q <= trans_cnt_d;
            pingpong_q  <= pingpong_d;
            past_end_q  <= past_end_d;
            err_q       <= err_d;
            bank_en_q   <= bank_en_d;
            bank_addr_q <= bank_addr_d;
            bank_dout_q <= bank_dout_d;
        end
    end

    assign wb.s_axis_tready = tready_s;
    assign wb.bank_en       = bank_en_q;
    assign wb.bank_addr     = bank_addr_q;
    assign wb.bank_dout     = bank_dout_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_DONE);
    assign err_len_o        = err_q;
endmodule

// File: tb/tb_weight_bank_writer.sv
// Scoreboard bench for weight_bank_writer: the driver queues expected BRAM
// writes per accepted beat, a negedge monitor pops and compares them.
module tb_weight_bank_writer;
    logic        clk;
    logic        rst;
    logic        start_i;
    logic [10:0] cfg_words_m1_i;
    logic [1:0]  cfg_trans_m1_i;
    logic [11:0] cfg_pong_base_i;
    logic        cfg_pp_en_i;
    logic        busy_o;
    logic        done_o;
    logic        err_len_o;

    weight_bank_writer_if #(.DATA_WIDTH(64), .NUM_BANKS(8), .ADDR_WIDTH(12)) wb ();

    weight_bank_writer #(
        .DATA_WIDTH(64), .NUM_BANKS(8), .ADDR_WIDTH(12), .CNT_WIDTH(11), .TRANS_WIDTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .cfg_words_m1_i (cfg_words_m1_i),
        .cfg_trans_m1_i (cfg_trans_m1_i),
        .cfg_pong_base_i(cfg_pong_base_i),
        .cfg_pp_en_i    (cfg_pp_en_i),
        .wb             (wb),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_len_o      (err_len_o)
    );

    typedef struct {
        logic [7:0]  en;
        logic [11:0] addr;
        logic [63:0] data;
        longint      cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    int     done_cnt = 0;
    int     loads = 0;
    longint cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to verify the one-cycle write latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every BRAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (wb.bank_en != 8'h00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: en=%h addr=%0d data=%h, required no write",
                         wb.bank_en, wb.bank_addr, wb.bank_dout);
            end else begin
                mon_e = sb.pop_front();
                if (wb.bank_en !== mon_e.en || wb.bank_addr !== mon_e.addr ||
                    wb.bank_dout !== mon_e.data || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL write: got en=%h addr=%0d data=%h cyc=%0d, required en=%h addr=%0d data=%h cyc=%0d",
                             wb.bank_en, wb.bank_addr, wb.bank_dout, cyc,
                             mon_e.en, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l,
                             input logic [7:0] en, input logic [11:0] addr);
        int t;
        @(negedge clk);
        wb.s_axis_tvalid = 1'b1;
        wb.s_axis_tdata  = d;
        wb.s_axis_tlast  = l;
        t = 0;
        while (!wb.s_axis_tready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!wb.s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: got tready=0, required 1 within 64 cycles");
            wb.s_axis_tvalid = 1'b0;
        end else begin
            sb.push_back('{en: en, addr: addr, data: d, cyc: cyc + 1});
        end
    endtask

    // Beat k goes to bank (k/words)%8 at base + k%words; optional start pulse at beat start_at.
    task automatic xfer(input int nbeats, input int tlast_at, input logic [11:0] base,
                        input int words, input int maxgap, input int start_at);
        int          gap;
        logic [7:0]  en;
        logic [11:0] addr;
        logic [63:0] d;
        for (int k = 0; k < nbeats; k++) begin
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                @(negedge clk);
                wb.s_axis_tvalid = 1'b0;
            end
            if (k == start_at) begin
                start_i        = 1'b1;
                cfg_words_m1_i = 11'd0;
            end
            en   = 8'h01 << ((k / words) % 8);
            addr = base + 12'(k % words);
            d    = {8'hA5, 8'(loads), 16'(k), $urandom};
            send_beat(d, (k == tlast_at), en, addr);
            if (k == start_at) begin
                start_i        = 1'b0;
                cfg_words_m1_i = 11'd3;
            end
        end
    endtask

    task automatic do_start(input logic [10:0] wm1, input logic [1:0] tm1,
                            input logic [11:0] pong, input logic pp);
        @(negedge clk);
        cfg_words_m1_i  = wm1;
        cfg_trans_m1_i  = tm1;
        cfg_pong_base_i = pong;
        cfg_pp_en_i     = pp;
        start_i         = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        check("err_cleared_by_start", 64'(err_len_o), 64'd0);
    endtask

    task automatic finish_load(input logic err_req);
        @(negedge clk);
        wb.s_axis_tvalid = 1'b0;
        wb.s_axis_tlast  = 1'b0;
        check("tready_low_after_last", 64'(wb.s_axis_tready), 64'd0);
        check("done_pulse", 64'(done_o), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'(done_o), 64'd0);
        check("idle_after_done", 64'(busy_o), 64'd0);
        check("err_len", 64'(err_len_o), 64'(err_req));
        loads++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, 64'(wb.s_axis_tready), 64'd0);
        check({tag, "_bank_en"}, 64'(wb.bank_en), 64'd0);
        check({tag, "_bank_addr"}, 64'(wb.bank_addr), 64'd0);
        check({tag, "_bank_dout"}, wb.bank_dout, 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_err_len"}, 64'(err_len_o), 64'd0);
    endtask

    initial begin
        rst              = 1'b1;
        start_i          = 1'b0;
        cfg_words_m1_i   = 11'd0;
        cfg_trans_m1_i   = 2'd0;
        cfg_pong_base_i  = 12'd0;
        cfg_pp_en_i      = 1'b0;
        wb.s_axis_tvalid = 1'b0;
        wb.s_axis_tdata  = 64'd0;
        wb.s_axis_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // Two full transfers, ping then pong, no gaps.
        do_start(11'd3, 2'd1, 12'd2048, 1'b1);
        xfer(32, 31, 12'd0, 4, 0, -1);
        xfer(32, 31, 12'd2048, 4, 0, -1);
        finish_load(1'b0);

        // Same configuration with random valid gaps.
        do_start(11'd3, 2'd1, 12'd2048, 1'b1);
        xfer(32, 31, 12'd0, 4, 3, -1);
        xfer(32, 31, 12'd2048, 4, 3, -1);
        finish_load(1'b0);

        // Ping/pong disabled, three transfers all at base 0.
        do_start(11'd3, 2'd2, 12'd2048, 1'b0);
        for (int t = 0; t < 3; t++) xfer(32, 31, 12'd0, 4, 1, -1);
        finish_load(1'b0);

        // Early TLAST on beat 10; the next beat opens transfer 1 at bank0/2048.
        do_start(11'd3, 2'd1, 12'd2048, 1'b1);
        xfer(10, 9, 12'd0, 4, 0, -1);
        xfer(32, 31, 12'd2048, 4, 0, -1);
        finish_load(1'b1);

        // Start pulse with a different word count mid-load is ignored; err_len cleared.
        do_start(11'd3, 2'd0, 12'd2048, 1'b1);
        xfer(32, 31, 12'd0, 4, 0, 16);
        finish_load(1'b0);

        // One word per bank: a ninth beat wraps to bank0 and flags an error.
        do_start(11'd0, 2'd0, 12'd100, 1'b1);
        xfer(9, 8, 12'd0, 1, 0, -1);
        finish_load(1'b1);

        // Reset after 5 beats with a beat in flight, then a fresh load.
        do_start(11'd3, 2'd0, 12'd2048, 1'b1);
        xfer(5, -1, 12'd0, 4, 0, -1);
        @(negedge clk);
        wb.s_axis_tdata = 64'hDEAD_BEEF_0000_0005;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wb.s_axis_tvalid = 1'b0;
        check_all_zero("abort");
        @(negedge clk);
        check("no_write_after_abort", 64'(wb.bank_en), 64'd0);
        do_start(11'd3, 2'd0, 12'd2048, 1'b1);
        xfer(32, 31, 12'd0, 4, 0, -1);
        finish_load(1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("done_count", 64'(done_cnt), 64'(loads));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
